// File: rtl/func_obuf.sv
// Output stage of the CIM pipeline: sums per-tile column partial sums, applies
// ReLU / shift requantisation / saturation and buffers one element per neuron.
module func_obuf #(
    parameter int unsigned datatype_size = 8,
    parameter int unsigned psum_size     = 24,
    parameter int unsigned input_size    = 201,
    parameter int unsigned xbar_size     = 256,
    parameter int unsigned v_cim_tiles   = (input_size + xbar_size - 1) / xbar_size,
    parameter int unsigned output_size   = 512,
    parameter int unsigned shift         = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        i_start,
    input  logic                                        i_cim_valid,
    input  logic [v_cim_tiles-1:0][psum_size-1:0]       i_cim_data,
    input  logic                                        i_next_busy,
    output logic                                        o_busy,
    output logic                                        o_valid,
    output logic [output_size-1:0][datatype_size-1:0]   o_data
);

    localparam int unsigned SUM_W = psum_size + $clog2(v_cim_tiles) + 1;
    localparam int unsigned CNT_W = (output_size > 1) ? $clog2(output_size) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(output_size - 1);
    localparam logic [SUM_W-1:0] SAT_MAX  = SUM_W'((2 ** datatype_size) - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HANDOFF
    } state_t;

    state_t                    state;
    logic [CNT_W-1:0]          count;
    logic signed [SUM_W-1:0]   sum_c;
    logic [SUM_W-1:0]          shifted_c;
    logic [datatype_size-1:0]  col_res_c;

    // Column datapath: tile reduction, ReLU, requantising shift, saturation.
    always_comb begin
        sum_c     = '0;
        shifted_c = '0;
        col_res_c = '0;
        for (int unsigned t = 0; t < v_cim_tiles; t++) begin
            sum_c = sum_c + SUM_W'($signed(i_cim_data[t]));
        end
        shifted_c = SUM_W'(sum_c >>> shift);
        if (sum_c[SUM_W-1]) begin
            col_res_c = '0;
        end else if (shifted_c > SAT_MAX) begin
            col_res_c = '1;
        end else begin
            col_res_c = shifted_c[datatype_size-1:0];
        end
    end

    // Frame control; o_busy/o_valid are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state  <= ACCUM;
                        count  <= '0;
                        o_busy <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (i_cim_valid) begin
                        o_data[count] <= col_res_c;
                        if (count == LAST_COL) begin
                            state   <= HANDOFF;
                            count   <= '0;
                            o_valid <= 1'b1;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                HANDOFF: begin
                    if (!i_next_busy) begin
                        state   <= IDLE;
                        o_busy  <= 1'b0;
                        o_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    count   <= '0;
                    o_busy  <= 1'b0;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/func_obuf.md
Name: func_obuf

Overview:
- Downstream stage of the CIM input controller.
- Consumes per-column partial sums streamed out of the v_cim_tiles vertically stacked crossbars and adds them across tiles.
- Applies ReLU, right-shift requantisation and saturation, then stores one result per output neuron into a register buffer.
- Drives the busy signal that the input controller samples as i_func_busy, and hands the finished vector to the next layer with a valid/busy handshake.

Parameters:
- datatype_size, 8, width of each stored output element (unsigned).
- psum_size, 24, width of each signed partial sum from one crossbar column.
- input_size, 201, layer input length; used only to derive v_cim_tiles.
- xbar_size, 256, crossbar rows per tile.
- v_cim_tiles, (input_size+xbar_size-1)/xbar_size, number of partial sums per column (ceiled division).
- output_size, 512, number of output neurons (columns) per frame.
- shift, 8, arithmetic right-shift applied after ReLU.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  frame start from the input controller, sampled in IDLE only.
- i_cim_valid  in  1  a column of partial sums is present this cycle.
- i_cim_data  in  psum_size x [v_cim_tiles]  signed partial sums for the current column, one per vertical tile.
- i_next_busy  in  1  next layer cannot accept the vector.
- o_busy  out  1  block owns the frame; goes to the input controller's i_func_busy.
- o_valid  out  1  o_data holds a complete frame.
- o_data  out  datatype_size x [output_size]  requantised output vector.

Behaviour:
- Reset: state IDLE, column counter 0, o_busy=0, o_valid=0, every o_data element 0. Reset mid-frame behaves the same and discards the partial frame.
- Registered o_busy and o_valid: both decoded from the current state only.
- IDLE: o_busy=0, o_valid=0. i_cim_valid ignored. i_start=1 -> ACCUM with count=0.
- ACCUM: o_busy=1. Each cycle with i_cim_valid=1, the processed column is written to o_data[count] at that clock edge (1-cycle latency), and count increments. i_cim_valid=0 holds everything. A valid column at count==output_size-1 -> HANDOFF and count returns to 0. i_start is ignored.
- HANDOFF: o_busy=1, o_valid=1. When i_next_busy=0 in a cycle, the transfer completes and the block moves to IDLE; o_valid and o_busy fall the next cycle. When i_next_busy=1, the state holds indefinitely. i_cim_valid and i_start are ignored.
- o_data persists after HANDOFF until overwritten element by element by the next frame; it is not cleared between frames.
- Arithmetic, per column:
  - sum = signed sum of the v_cim_tiles partial sums, sign-extended to psum_size+$clog2(v_cim_tiles)+1 bits (no overflow possible).
  - ReLU: sum<0 -> 0.
  - Shift: r = sum >>> shift.
  - Saturate: r > 2^datatype_size-1 -> 2^datatype_size-1, otherwise the low datatype_size bits.
  - With v_cim_tiles=1 the adder degenerates to a pass-through.
- count width is $clog2(output_size), minimum 1 bit. count never exceeds output_size-1.
- Simultaneous i_start and rst: rst wins.
- i_next_busy is don't-care outside HANDOFF.

Test Plan:
- Reset/idle (defaults): hold rst for 2 cycles with i_cim_valid=1 and random data -> o_busy=0, o_valid=0, all o_data=0, and they stay so after release with i_start=0.
- Basic frame (output_size=4, input_size=300 so v_cim_tiles=2, shift=2): pulse i_start, stream columns {10,6}, {-20,4}, {600,500}, {3,0} back to back -> o_data={4,0,255,0}. o_busy rises the cycle after i_start; o_valid rises the cycle after the 4th column.
- Gaps in valid: same frame with i_cim_valid low for 3 cycles between columns 2 and 3 -> identical o_data, and HANDOFF is entered only after the 4th valid column.
- Handoff back-pressure: i_next_busy=1 for 5 cycles in HANDOFF -> o_valid and o_busy stay 1, o_data stable. Drop i_next_busy -> both fall one cycle later and the state returns to IDLE.
- Ignored inputs: i_start pulsed mid-ACCUM and extra i_cim_valid columns in HANDOFF -> count and o_data are unaffected. A second frame started from IDLE then overwrites o_data[0] first.
- Reset mid-frame: assert rst after 2 of 4 columns -> o_data all 0 and IDLE. A fresh frame then completes correctly with expected values.
